// File: rtl/cpu_pkg.sv
// Shared types and constants for the cpu_core slice: opcodes, instruction field positions, hex-to-segment decode.
// Latency: none (declarations only).
// Backpressure: not applicable.
package cpu_pkg;

    localparam int WORD_W = 16;

    // Instruction field positions
    localparam int OP_HI  = 15;
    localparam int OP_LO  = 12;
    localparam int RD_HI  = 11;
    localparam int RD_LO  = 8;
    localparam int RS_HI  = 7;
    localparam int RS_LO  = 4;
    localparam int IMM_W  = 8;
    localparam int BOFF_W = 4;
    localparam int JOFF_W = 9;

    localparam logic [WORD_W-1:0] HALT_WORD = 16'hFFFF;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_OR   = 4'h4,
        OP_ADDI = 4'h5,
        OP_LDI  = 4'h8,
        OP_LD   = 4'h9,
        OP_ST   = 4'hA,
        OP_BGT  = 4'hD,
        OP_JMP  = 4'hE,
        OP_HALT = 4'hF
    } op_e;

    // Hex digit to segments {dp,g,f,e,d,c,b,a}, active-high
    function automatic logic [7:0] hex7(input logic [3:0] n);
        logic [7:0] s;
        case (n)
            4'h0: s = 8'h3F;
            4'h1: s = 8'h06;
            4'h2: s = 8'h5B;
            4'h3: s = 8'h4F;
            4'h4: s = 8'h66;
            4'h5: s = 8'h6D;
            4'h6: s = 8'h7D;
            4'h7: s = 8'h07;
            4'h8: s = 8'h7F;
            4'h9: s = 8'h6F;
            4'hA: s = 8'h77;
            4'hB: s = 8'h7C;
            4'hC: s = 8'h39;
            4'hD: s = 8'h5E;
            4'hE: s = 8'h79;
            default: s = 8'h71;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/cpu_if.sv
// Board-facing bundle of cpu_core: step strobe, halt flag, segment outputs and the program-load port.
// Latency: none (wires only); program writes land on the next board_ck rising edge.
// Backpressure: none; the load port is write-only and always accepted.
interface cpu_if #(parameter int IMEM_AW = 8);
    logic               CLK;
    logic               do_halt;
    logic [7:0]         SEG_A;
    logic [7:0]         SEG_B;
    logic [7:0]         SEG_C;
    logic [7:0]         SEG_D;
    logic [7:0]         SEG_E;
    logic [7:0]         SEG_F;
    logic [7:0]         SEG_G;
    logic [7:0]         SEG_H;
    logic [8:0]         SEG_SEL_IK;
    logic [7:0]         SEG;
    logic [3:0]         SEG_SEL;
    logic               prog_we;
    logic [IMEM_AW-1:0] prog_addr;
    logic [15:0]        prog_dat;

    modport master (
        output CLK, do_halt,
        output SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F, SEG_G, SEG_H,
        output SEG_SEL_IK, SEG, SEG_SEL,
        input  prog_we, prog_addr, prog_dat
    );

    modport slave (
        input  CLK, do_halt,
        input  SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F, SEG_G, SEG_H,
        input  SEG_SEL_IK, SEG, SEG_SEL,
        output prog_we, prog_addr, prog_dat
    );
endinterface

// File: rtl/cpu_mem.sv
// Single-port-write word memory with an independent combinational read port; contents survive reset.
// Latency: read 0 cycles (combinational), write lands on the rising edge.
// Backpressure: none; every write is accepted.
module cpu_mem #(
    parameter int DEPTH = 256,
    parameter int W     = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdat,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdat
);
    logic [W-1:0] memory [DEPTH];

    // Synchronous write; storage is deliberately not reset so programs survive a core reset
    always_ff @(posedge clk) begin
        if (we) begin
            memory[waddr] <= wdat;
        end
    end

    assign rdat = memory[raddr];
endmodule

// File: rtl/cpu_regfile.sv
// 16x16 register file, two combinational read ports, one write port, r0 hardwired to zero.
// Latency: read 0 cycles, write visible after the rising edge.
// Backpressure: none.
module cpu_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  ra_addr,
    input  logic [3:0]  rb_addr,
    output logic [15:0] ra_dat,
    output logic [15:0] rb_dat,
    input  logic        we,
    input  logic [3:0]  wa,
    input  logic [15:0] wd
);
    logic [15:0] regs [16];

    // Register writes; r0 is never written so it stays at its reset value of zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (wa != 4'd0)) begin
            regs[wa] <= wd;
        end
    end

    assign ra_dat = (ra_addr == 4'd0) ? 16'h0000 : regs[ra_addr];
    assign rb_dat = (rb_addr == 4'd0) ? 16'h0000 : regs[rb_addr];
endmodule

// File: rtl/cpu_core.sv
// Single-issue 16-bit RISC core; executes one instruction every second board_ck edge, halts on opcode F.
// Latency: whole instruction (fetch..writeback) completes on its step edge; first step on the 2nd edge after reset.
// Backpressure: none; the core free-runs until HALT. Optional display build: define CPU_SEG_DISPLAY_EN.
module cpu_core
    import cpu_pkg::*;
#(
    parameter int IMEM_DEPTH = 256,
    parameter int DMEM_DEPTH = 256
) (
    input  logic board_ck,
    input  logic rst,
    cpu_if.master io
);
    localparam int IAW = $clog2(IMEM_DEPTH);
    localparam int DAW = $clog2(DMEM_DEPTH);

    typedef enum logic {ST_RUN = 1'b0, ST_HALTED = 1'b1} run_e;

    run_e          state_q, state_d;
    logic          clk_q;
    logic [15:0]   pc;
    logic [31:0]   cnt;
    logic          halted;
    logic          step;

    logic [15:0]   instr;
    logic [3:0]    op;
    logic [3:0]    rd;
    logic [3:0]    rs;
    logic [7:0]    imm8;
    logic [3:0]    boff;
    logic [8:0]    joff;
    logic [15:0]   rd_val;
    logic [15:0]   rs_val;
    logic [15:0]   dm_rdat;

    logic          wr_en;
    logic [15:0]   wr_dat;
    logic          dm_we;
    logic [15:0]   next_pc;
    logic          halt_hit;

    // The core commits at the end of each CLK-high phase, so CLK reads 1 while an instruction is in flight
    assign halted = (state_q == ST_HALTED);
    assign step   = clk_q && !halted;

    assign op   = instr[OP_HI:OP_LO];
    assign rd   = instr[RD_HI:RD_LO];
    assign rs   = instr[RS_HI:RS_LO];
    assign imm8 = instr[IMM_W-1:0];
    assign boff = instr[BOFF_W-1:0];
    assign joff = instr[JOFF_W-1:0];

    cpu_mem #(.DEPTH(IMEM_DEPTH), .W(WORD_W)) fetch_module (
        .clk   (board_ck),
        .we    (io.prog_we),
        .waddr (io.prog_addr),
        .wdat  (io.prog_dat),
        .raddr (pc[IAW-1:0]),
        .rdat  (instr)
    );

    cpu_regfile decode_module (
        .clk     (board_ck),
        .rst     (rst),
        .ra_addr (rd),
        .rb_addr (rs),
        .ra_dat  (rd_val),
        .rb_dat  (rs_val),
        .we      (step && wr_en),
        .wa      (rd),
        .wd      (wr_dat)
    );

    cpu_mem #(.DEPTH(DMEM_DEPTH), .W(WORD_W)) memory_module (
        .clk   (board_ck),
        .we    (step && dm_we),
        .waddr (rs_val[DAW-1:0]),
        .wdat  (rd_val),
        .raddr (rs_val[DAW-1:0]),
        .rdat  (dm_rdat)
    );

    // Decode and execute: writeback value, store enable and next pc for the current instruction
    always_comb begin
        wr_en    = 1'b0;
        wr_dat   = rd_val;
        dm_we    = 1'b0;
        next_pc  = pc + 16'd1;
        halt_hit = 1'b0;
        case (op)
            OP_ADD:  begin wr_en = 1'b1; wr_dat = rd_val + rs_val; end
            OP_SUB:  begin wr_en = 1'b1; wr_dat = rd_val - rs_val; end
            OP_AND:  begin wr_en = 1'b1; wr_dat = rd_val & rs_val; end
            OP_OR:   begin wr_en = 1'b1; wr_dat = rd_val | rs_val; end
            OP_ADDI: begin
                wr_en  = 1'b1;
                wr_dat = rd_val + {{(WORD_W-IMM_W){imm8[IMM_W-1]}}, imm8};
            end
            OP_LDI:  begin wr_en = 1'b1; wr_dat = {{(WORD_W-IMM_W){1'b0}}, imm8}; end
            OP_LD:   begin wr_en = 1'b1; wr_dat = dm_rdat; end
            OP_ST:   dm_we = 1'b1;
            OP_BGT:  begin
                if ($signed(rd_val) > $signed(rs_val)) begin
                    next_pc = pc + {{(WORD_W-BOFF_W){boff[BOFF_W-1]}}, boff};
                end
            end
            OP_JMP:  next_pc = pc + {{(WORD_W-JOFF_W){joff[JOFF_W-1]}}, joff};
            OP_HALT: begin halt_hit = 1'b1; next_pc = pc; end
            default: ;
        endcase
    end

    // Step strobe: toggles on every board_ck edge out of reset
    always_ff @(posedge board_ck or posedge rst) begin
        if (rst) begin
            clk_q <= 1'b0;
        end else begin
            clk_q <= ~clk_q;
        end
    end

    // Program counter and retired-instruction count advance on every non-HALT step
    always_ff @(posedge board_ck or posedge rst) begin
        if (rst) begin
            pc  <= '0;
            cnt <= '0;
        end else if (step && !halt_hit) begin
            pc  <= next_pc;
            cnt <= cnt + 32'd1;
        end
    end

    // Run/halt state register
    always_ff @(posedge board_ck or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Run/halt next state: executing HALT parks the core until reset
    always_comb begin
        state_d = state_q;
        if (step && halt_hit) begin
            state_d = ST_HALTED;
        end
    end

    assign io.CLK     = clk_q;
    assign io.do_halt = !halted;

`ifdef CPU_SEG_DISPLAY_EN
    logic [7:0] seg_a_q, seg_b_q, seg_c_q, seg_d_q;
    logic [7:0] seg_e_q, seg_f_q, seg_g_q, seg_h_q;
    logic [9:0] pre_q;
    logic [1:0] dig_q;
    logic [3:0] sel_q;
    logic [7:0] mux_q;

    // Static digits: pc on A..D, r7 on E..H, most significant nibble first
    always_ff @(posedge board_ck or posedge rst) begin
        if (rst) begin
            seg_a_q <= '0; seg_b_q <= '0; seg_c_q <= '0; seg_d_q <= '0;
            seg_e_q <= '0; seg_f_q <= '0; seg_g_q <= '0; seg_h_q <= '0;
        end else begin
            seg_a_q <= hex7(pc[15:12]);
            seg_b_q <= hex7(pc[11:8]);
            seg_c_q <= hex7(pc[7:4]);
            seg_d_q <= hex7(pc[3:0]);
            seg_e_q <= hex7(decode_module.regs[7][15:12]);
            seg_f_q <= hex7(decode_module.regs[7][11:8]);
            seg_g_q <= hex7(decode_module.regs[7][7:4]);
            seg_h_q <= hex7(decode_module.regs[7][3:0]);
        end
    end

    // Multiplexed display scans cnt[15:0], moving to the next digit every 1024 board_ck cycles
    always_ff @(posedge board_ck or posedge rst) begin
        if (rst) begin
            pre_q <= '0;
            dig_q <= '0;
            sel_q <= 4'b0001;
            mux_q <= '0;
        end else begin
            pre_q <= pre_q + 10'd1;
            if (&pre_q) begin
                dig_q <= dig_q + 2'd1;
                sel_q <= {sel_q[2:0], sel_q[3]};
            end
            mux_q <= hex7(cnt[{dig_q, 2'b00} +: 4]);
        end
    end

    assign io.SEG_A      = seg_a_q;
    assign io.SEG_B      = seg_b_q;
    assign io.SEG_C      = seg_c_q;
    assign io.SEG_D      = seg_d_q;
    assign io.SEG_E      = seg_e_q;
    assign io.SEG_F      = seg_f_q;
    assign io.SEG_G      = seg_g_q;
    assign io.SEG_H      = seg_h_q;
    assign io.SEG_SEL_IK = 9'h1FF;
    assign io.SEG        = mux_q;
    assign io.SEG_SEL    = sel_q;
`else
    assign io.SEG_A      = '0;
    assign io.SEG_B      = '0;
    assign io.SEG_C      = '0;
    assign io.SEG_D      = '0;
    assign io.SEG_E      = '0;
    assign io.SEG_F      = '0;
    assign io.SEG_G      = '0;
    assign io.SEG_H      = '0;
    assign io.SEG_SEL_IK = '0;
    assign io.SEG        = '0;
    assign io.SEG_SEL    = '0;
`endif

endmodule

// File: tb/tb_cpu_core.sv
// Directed bench for cpu_core: reset state, bit-scan program timing, mid-run reset and a table of short programs.
// Latency: checks commit on the exact board_ck edge counted from reset release.
// Backpressure: not applicable.
module tb_cpu_core;
    import cpu_pkg::*;

    logic board_ck = 1'b0;
    logic rst      = 1'b1;

    cpu_if #(.IMEM_AW(8)) io ();

    cpu_core #(.IMEM_DEPTH(256), .DMEM_DEPTH(256)) dut (
        .board_ck (board_ck),
        .rst      (rst),
        .io       (io)
    );

    always #5 board_ck = ~board_ck;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [7:0][15:0] prog;
        logic [3:0]       reg_idx;
        logic [15:0]      exp_val;
        logic [31:0]      exp_cnt;
    } vec_t;

    vec_t vecs [12];

    logic [15:0] bitscan [19] = '{
        16'h0000, 16'h8208, 16'h8301, 16'h8400, 16'h3500, 16'h1530, 16'h3520,
        16'hD505, 16'h1330, 16'h5301, 16'h5401, 16'hE1F9, 16'h8600, 16'h8700,
        16'h1770, 16'h5701, 16'h5601, 16'hD46D, 16'hFFFF
    };

    function automatic logic [7:0][15:0] p8(input logic [15:0] a, b, c, d, e);
        logic [7:0][15:0] r;
        r    = {8{HALT_WORD}};
        r[0] = a; r[1] = b; r[2] = c; r[3] = d; r[4] = e;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic load_word(input logic [7:0] a, input logic [15:0] d);
        @(negedge board_ck);
        io.prog_we   = 1'b1;
        io.prog_addr = a;
        io.prog_dat  = d;
        @(negedge board_ck);
        io.prog_we   = 1'b0;
    endtask

    // Counts rising edges from release until do_halt is seen low; -1 if the budget runs out
    task automatic run_to_halt(input int budget, output int edges);
        bit done;
        done  = 1'b0;
        edges = -1;
        for (int i = 1; i <= budget && !done; i++) begin
            @(posedge board_ck);
            @(negedge board_ck);
            if (io.do_halt === 1'b0) begin
                edges = i;
                done  = 1'b1;
            end
        end
    endtask

    task automatic release_rst();
        repeat (3) @(posedge board_ck);
        @(negedge board_ck);
        rst = 1'b0;
    endtask

    initial begin
        int          edges;
        logic [15:0] acc;

        io.prog_we   = 1'b0;
        io.prog_addr = '0;
        io.prog_dat  = '0;

        vecs[0]  = '{p8(16'h81FF, 16'h5101, 16'h2210, 16'hFFFF, 16'hFFFF), 4'd1, 16'h0100, 32'd3};
        vecs[1]  = '{p8(16'h81FF, 16'h5101, 16'h2210, 16'hFFFF, 16'hFFFF), 4'd2, 16'hFF00, 32'd3};
        vecs[2]  = '{p8(16'h81FF, 16'h5101, 16'h5180, 16'hFFFF, 16'hFFFF), 4'd1, 16'h0080, 32'd3};
        vecs[3]  = '{p8(16'h8005, 16'h8102, 16'h1100, 16'hFFFF, 16'hFFFF), 4'd1, 16'h0002, 32'd3};
        vecs[4]  = '{p8(16'h8103, 16'h825A, 16'hA210, 16'h9310, 16'hFFFF), 4'd3, 16'h005A, 32'd4};
        vecs[5]  = '{p8(16'h81C3, 16'h825A, 16'h4120, 16'hFFFF, 16'hFFFF), 4'd1, 16'h00DB, 32'd3};
        vecs[6]  = '{p8(16'h81C3, 16'h825A, 16'h3120, 16'hFFFF, 16'hFFFF), 4'd1, 16'h0042, 32'd3};
        vecs[7]  = '{p8(16'h8101, 16'h2210, 16'hD122, 16'h8311, 16'hFFFF), 4'd3, 16'h0000, 32'd3};
        vecs[8]  = '{p8(16'h8105, 16'h8205, 16'hD122, 16'h8322, 16'hFFFF), 4'd3, 16'h0022, 32'd4};
        vecs[9]  = '{p8(16'hE002, 16'h8401, 16'h8507, 16'hFFFF, 16'hFFFF), 4'd5, 16'h0007, 32'd2};
        vecs[10] = '{p8(16'hE002, 16'h8401, 16'h8507, 16'hFFFF, 16'hFFFF), 4'd4, 16'h0000, 32'd2};
        vecs[11] = '{p8(16'h6123, 16'hB456, 16'hC789, 16'h8109, 16'hFFFF), 4'd1, 16'h0009, 32'd4};

        // Reset state with the bit-scan program loaded
        for (int i = 0; i < 19; i++) load_word(8'(i), bitscan[i]);
        release_rst();
        #1;
        chk("rst_pc", 32'(dut.pc), 32'd0);
        chk("rst_clk", 32'(io.CLK), 32'd0);
        chk("rst_do_halt", 32'(io.do_halt), 32'd1);
        chk("rst_cnt", dut.cnt, 32'd0);
        acc = '0;
        for (int i = 0; i < 16; i++) acc = acc | dut.decode_module.regs[i];
        chk("rst_regs", 32'(acc), 32'd0);
`ifdef CPU_SEG_DISPLAY_EN
        chk("rst_seg_sel", 32'(io.SEG_SEL), 32'h1);
        chk("seg_sel_ik", 32'(io.SEG_SEL_IK), 32'h1FF);
`else
        chk("seg_off", 32'(|{io.SEG_A, io.SEG_B, io.SEG_C, io.SEG_D, io.SEG_E, io.SEG_F,
                             io.SEG_G, io.SEG_H, io.SEG_SEL_IK, io.SEG, io.SEG_SEL}), 32'd0);
`endif

        // Bit-scan program: halt edge, results, then freeze after HALT
        run_to_halt(200, edges);
        chk("scan_halt_edge", 32'(edges), 32'd94);
        chk("scan_r7", 32'(dut.decode_module.regs[7]), 32'd7);
        chk("scan_r4", 32'(dut.decode_module.regs[4]), 32'd3);
        chk("scan_r3", 32'(dut.decode_module.regs[3]), 32'd15);
        chk("scan_cnt", dut.cnt, 32'd46);
        repeat (20) begin
            @(posedge board_ck);
        end
        @(negedge board_ck);
        chk("freeze_pc", 32'(dut.pc), 32'd18);
        chk("freeze_cnt", dut.cnt, 32'd46);
        chk("freeze_do_halt", 32'(io.do_halt), 32'd0);
        chk("clk_edge114", 32'(io.CLK), 32'd0);
        @(posedge board_ck);
        @(negedge board_ck);
        chk("clk_edge115", 32'(io.CLK), 32'd1);

        // Mid-run reset: restart the program, interrupt it, then let it run to completion
        rst = 1'b1;
        release_rst();
        @(posedge board_ck);
        @(negedge board_ck);
        chk("e1_clk", 32'(io.CLK), 32'd1);
        chk("e1_cnt", dut.cnt, 32'd0);
        @(posedge board_ck);
        @(negedge board_ck);
        chk("e2_clk", 32'(io.CLK), 32'd0);
        chk("e2_cnt", dut.cnt, 32'd1);
        repeat (38) @(posedge board_ck);
        @(negedge board_ck);
        #2 rst = 1'b1;
        #1;
        chk("mid_pc", 32'(dut.pc), 32'd0);
        chk("mid_r2", 32'(dut.decode_module.regs[2]), 32'd0);
        chk("mid_cnt", dut.cnt, 32'd0);
        chk("mid_do_halt", 32'(io.do_halt), 32'd1);
        chk("mid_clk", 32'(io.CLK), 32'd0);
        release_rst();
        run_to_halt(200, edges);
        chk("rerun_halt_edge", 32'(edges), 32'd94);
        chk("rerun_r7", 32'(dut.decode_module.regs[7]), 32'd7);
        chk("rerun_r3", 32'(dut.decode_module.regs[3]), 32'd15);

        // Short-program table
        for (int v = 0; v < 12; v++) begin
            rst = 1'b1;
            for (int w = 0; w < 8; w++) load_word(8'(w), vecs[v].prog[w]);
            release_rst();
            run_to_halt(100, edges);
            chk($sformatf("vec%0d_halted", v), 32'(edges > 0), 32'd1);
            chk($sformatf("vec%0d_r%0d", v, vecs[v].reg_idx),
                32'(dut.decode_module.regs[vecs[v].reg_idx]), 32'(vecs[v].exp_val));
            chk($sformatf("vec%0d_cnt", v), dut.cnt, vecs[v].exp_cnt);
            if (v == 3) chk("vec3_r0", 32'(dut.decode_module.regs[0]), 32'd0);
            if (v == 4) chk("vec4_dmem3", 32'(dut.memory_module.memory[3]), 32'h5A);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
